// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetches 16-bit halfwords, assembles 16/32-bit
// instructions for the decoder, owns the PC and handles branch redirects.
module fetch_unit #(
  parameter int unsigned PC_WIDTH = 24
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_data,
  input  logic                imem_valid,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [31:0]         fetchoutput,
  output logic                fetch_valid,
  output logic [PC_WIDTH-1:0] fetch_pc
);

  typedef enum logic [2:0] {
    S_RESET,
    S_REQ1,
    S_WAIT1,
    S_REQ2,
    S_WAIT2,
    S_FULL,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         hw1_q, hw1_d;
  logic [31:0]         out_q, out_d;
  logic [PC_WIDTH-1:0] fpc_q, fpc_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      pc_q    <= '0;
      hw1_q   <= '0;
      out_q   <= '0;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hw1_q   <= hw1_d;
      out_q   <= out_d;
      fpc_q   <= fpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hw1_d   = hw1_q;
    out_d   = out_q;
    fpc_d   = fpc_q;

    unique case (state_q)
      S_RESET: state_d = S_REQ1;
      S_REQ1:  state_d = S_WAIT1;
      S_WAIT1: begin
        if (imem_valid) begin
          if (imem_data[15]) begin
            hw1_d   = imem_data;
            state_d = S_REQ2;
          end else begin
            out_d   = {imem_data, 16'h0000};
            fpc_d   = pc_q;
            pc_d    = pc_q + PC_WIDTH'(1);
            state_d = S_FULL;
          end
        end
      end
      S_REQ2:  state_d = S_WAIT2;
      S_WAIT2: begin
        if (imem_valid) begin
          out_d   = {hw1_q, imem_data};
          fpc_d   = pc_q;
          pc_d    = pc_q + PC_WIDTH'(2);
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (!stall) state_d = S_REQ1;
      end
      S_DRAIN: begin
        if (imem_valid) state_d = S_REQ1;
      end
      default: state_d = S_RESET;
    endcase

    // A redirect overrides any load; a response still owed by memory is
    // absorbed in DRAIN, including one arriving in the same cycle as a
    // re-branch from DRAIN.
    if (branch_taken) begin
      pc_d  = branch_target;
      out_d = out_q;
      fpc_d = fpc_q;
      hw1_d = hw1_q;
      if ((state_q == S_WAIT1 || state_q == S_WAIT2 || state_q == S_DRAIN)
          && !imem_valid) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_REQ1;
      end
    end
  end

  // Request is withheld under a redirect so the re-issue from REQ1 never
  // overlaps a request to the stale address.
  assign imem_req    = (state_q == S_REQ1 || state_q == S_REQ2) && !branch_taken;
  assign imem_addr   = (state_q == S_REQ2) ? pc_q + PC_WIDTH'(1) : pc_q;
  assign fetchoutput = out_q;
  assign fetch_pc    = fpc_q;
  assign fetch_valid = (state_q == S_FULL);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected requests
// and instructions; a monitor pops and compares as the DUT presents them.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [23:0] imem_addr;
  logic [15:0] imem_data = '0;
  logic        imem_valid = 1'b0;
  logic        stall = 1'b1;
  logic        branch_taken = 1'b0;
  logic [23:0] branch_target = '0;
  logic [31:0] fetchoutput;
  logic        fetch_valid;
  logic [23:0] fetch_pc;

  int total = 0;
  int bad   = 0;

  logic [23:0] req_q[$];
  logic [31:0] out_q[$];
  logic [23:0] opc_q[$];

  int          lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [23:0] paddr = '0;

  fetch_unit #(.PC_WIDTH(24)) dut (
    .clock        (clock),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .imem_valid   (imem_valid),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .fetchoutput  (fetchoutput),
    .fetch_valid  (fetch_valid),
    .fetch_pc     (fetch_pc)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem(input logic [23:0] a);
    case (a)
      24'h000000: mem = 16'h1234;
      24'h000001: mem = 16'h0011;
      24'h000002: mem = 16'h0022;
      24'h000003: mem = 16'h0033;
      24'h000004: mem = 16'h8A01;
      24'h000005: mem = 16'h8003;
      24'hFFFFFF: mem = 16'h8FFF;
      default:    mem = {1'b0, a[14:0]};
    endcase
  endfunction

  // Memory model: response arrives 'lat' cycles after the request.
  always @(negedge clock) begin
    #2;
    imem_valid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_valid = 1'b1;
        imem_data  = mem(paddr);
        pend       = 1'b0;
      end
    end
    if (imem_req) begin
      check("one_outstanding", {63'd0, pend}, 64'd0);
      if (!pend) begin
        pend  = 1'b1;
        paddr = imem_addr;
        cnt   = lat;
      end
    end
  end

  // Monitor: requests and transfers against the scoreboard queues.
  always @(negedge clock) begin
    #1;
    if (reset) begin
      if (imem_req) begin
        if (req_q.size() == 0) check("req_unexpected", {40'd0, imem_addr}, 64'hDEAD);
        else check("req_addr", {40'd0, imem_addr}, {40'd0, req_q.pop_front()});
      end
      if (fetch_valid && !stall) begin
        if (out_q.size() == 0) begin
          check("out_unexpected", {32'd0, fetchoutput}, 64'hDEAD);
        end else begin
          check("fetchoutput", {32'd0, fetchoutput}, {32'd0, out_q.pop_front()});
          check("fetch_pc", {40'd0, fetch_pc}, {40'd0, opc_q.pop_front()});
        end
      end
    end
  end

  task automatic push_out(input logic [31:0] o, input logic [23:0] p);
    out_q.push_back(o);
    opc_q.push_back(p);
  endtask

  task automatic wait_fv();
    for (int i = 0; i < 40; i++) begin
      @(negedge clock); #3;
      if (fetch_valid) break;
    end
    check("fv_arrives", {63'd0, fetch_valid}, 64'd1);
  endtask

  task automatic wait_req(input logic [23:0] a);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock); #3;
      if (imem_req && imem_addr == a) begin
        hit = 1'b1;
        break;
      end
    end
    check("req_arrives", {63'd0, hit}, 64'd1);
  endtask

  // Transfer the held instruction, then measure cycles to the next one.
  task automatic step(input int exp_cyc);
    int n;
    @(negedge clock); stall = 1'b0;
    @(negedge clock); stall = 1'b1; #3;
    check("fv_drops", {63'd0, fetch_valid}, 64'd0);
    n = 1;
    while (!fetch_valid && n < 40) begin
      @(negedge clock); #3;
      n++;
    end
    check("next_latency", 64'(n), 64'(exp_cyc));
  endtask

  task automatic check_reset_outs();
    check("rst_req", {63'd0, imem_req}, 64'd0);
    check("rst_addr", {40'd0, imem_addr}, 64'd0);
    check("rst_fo", {32'd0, fetchoutput}, 64'd0);
    check("rst_fv", {63'd0, fetch_valid}, 64'd0);
    check("rst_fpc", {40'd0, fetch_pc}, 64'd0);
  endtask

  initial begin
    logic seen, prevv;
    repeat (3) @(negedge clock);
    #3;
    check_reset_outs();

    // Straight-line fetch: 16-bit, then a 32-bit pair at 4/5.
    foreach (req_q[i]) req_q.delete(i);
    for (int a = 0; a <= 6; a++) req_q.push_back(24'(a));
    push_out(32'h1234_0000, 24'd0);
    push_out(32'h0011_0000, 24'd1);
    push_out(32'h0022_0000, 24'd2);
    push_out(32'h0033_0000, 24'd3);
    push_out(32'h8A01_8003, 24'd4);
    @(negedge clock); reset = 1'b1;
    wait_fv();
    repeat (5) begin
      @(negedge clock); #3;
      check("stall_fo", {32'd0, fetchoutput}, 64'h1234_0000);
      check("stall_fpc", {40'd0, fetch_pc}, 64'd0);
      check("stall_fv", {63'd0, fetch_valid}, 64'd1);
      check("stall_noreq", {63'd0, imem_req}, 64'd0);
    end
    step(3);
    step(3);
    step(3);
    step(5);
    step(3);

    // Branch in FULL under stall: held instruction dropped.
    req_q.push_back(24'h000010);
    @(negedge clock); branch_taken = 1'b1; branch_target = 24'h000010;
    @(negedge clock); branch_taken = 1'b0; #3;
    check("brfull_fv", {63'd0, fetch_valid}, 64'd0);
    check("brfull_req", {63'd0, imem_req}, 64'd1);
    wait_fv();
    check("br_fo", {32'd0, fetchoutput}, 64'h0010_0000);
    check("br_fpc", {40'd0, fetch_pc}, 64'h10);

    // Branch during WAIT2 with slow memory: late response drained.
    lat = 3;
    req_q.push_back(24'h000004);
    req_q.push_back(24'h000005);
    req_q.push_back(24'h000100);
    push_out(32'h0100_0000, 24'h000100);
    @(negedge clock); branch_taken = 1'b1; branch_target = 24'h000004;
    @(negedge clock); branch_taken = 1'b0;
    wait_req(24'h000005);
    @(negedge clock); branch_taken = 1'b1; branch_target = 24'h000100;
    @(negedge clock); branch_taken = 1'b0;
    seen = 1'b0; prevv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #3;
      if (imem_req) begin
        seen = 1'b1;
        break;
      end
      prevv = imem_valid;
      @(negedge clock);
    end
    check("drain_req", {63'd0, seen}, 64'd1);
    check("drain_after_valid", {63'd0, prevv}, 64'd1);
    check("drain_fv", {63'd0, fetch_valid}, 64'd0);
    wait_fv();

    // Branch coincident with the WAIT1 response.
    lat = 1;
    req_q.push_back(24'h000101);
    req_q.push_back(24'h000200);
    push_out(32'h0200_0000, 24'h000200);
    @(negedge clock); stall = 1'b0;
    @(negedge clock); stall = 1'b1;
    @(negedge clock); branch_taken = 1'b1; branch_target = 24'h000200; #3;
    check("coinc_valid", {63'd0, imem_valid}, 64'd1);
    @(negedge clock); branch_taken = 1'b0; #3;
    check("coinc_fv", {63'd0, fetch_valid}, 64'd0);
    check("coinc_req", {63'd0, imem_req}, 64'd1);
    wait_fv();
    req_q.push_back(24'h000201);
    step(3);

    // 32-bit instruction at the top of the address space wraps to 0.
    req_q.push_back(24'hFFFFFF);
    req_q.push_back(24'h000000);
    req_q.push_back(24'h000001);
    push_out(32'h8FFF_1234, 24'hFFFFFF);
    @(negedge clock); branch_taken = 1'b1; branch_target = 24'hFFFFFF;
    @(negedge clock); branch_taken = 1'b0;
    wait_fv();
    step(3);

    // Reset mid-WAIT2; stale response lands in RESET and is ignored.
    lat = 3;
    req_q.push_back(24'h000004);
    req_q.push_back(24'h000005);
    @(negedge clock); branch_taken = 1'b1; branch_target = 24'h000004;
    @(negedge clock); branch_taken = 1'b0;
    wait_req(24'h000005);
    @(negedge clock); reset = 1'b0; #3;
    check_reset_outs();
    req_q.push_back(24'h000000);
    push_out(32'h1234_0000, 24'd0);
    req_q.push_back(24'h000001);
    @(negedge clock);
    @(negedge clock); reset = 1'b1; #3;
    check("stale_valid", {63'd0, imem_valid}, 64'd1);
    check("stale_noreq", {63'd0, imem_req}, 64'd0);
    wait_fv();
    check("restart_fo", {32'd0, fetchoutput}, 64'h1234_0000);
    @(negedge clock); stall = 1'b0;
    @(negedge clock); stall = 1'b1;
    repeat (10) @(negedge clock);
    #3;
    check("req_q_empty", 64'(req_q.size()), 64'd0);
    check("out_q_empty", 64'(out_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
